// File: rtl/irq_ctrl.sv
// irq_ctrl: machine timer, software and external interrupt sources feeding
// a single-request IDLE/REQ/BUSY handshake toward the CSR file.
module irq_ctrl #(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [31:0] bus_rdata,
    output logic        bus_rvalid,
    input  logic        ext_irq_in,
    input  logic        irq_ack,
    input  logic        irq_done,
    output logic        irq_req,
    output logic [31:0] irq_cause,
    output logic [2:0]  mip_bits
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] BUSY = 2'd2;
    localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
    localparam logic [31:0] CAUSE_SW  = 32'h8000_0003;
    localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;

    logic [1:0]  state;
    logic [31:0] cause_q;
    logic [2:0]  ext_sync;
    logic        meip;
    logic        msip_q;
    logic        mtip;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] pcnt;
    logic        tick;
    logic        ext_rise;
    logic        wr_tlo, wr_thi, wr_clo, wr_chi, wr_sip;
    logic [31:0] rd_mux;

    assign tick     = pcnt == 32'(PRESCALE - 1);
    assign mtip     = mtime >= mtimecmp;
    // ext_sync[1] is the synchronized level; ext_sync[2] is its previous value
    assign ext_rise = ext_sync[1] & ~ext_sync[2];
    assign wr_tlo   = bus_we && bus_addr == 5'h00;
    assign wr_thi   = bus_we && bus_addr == 5'h04;
    assign wr_clo   = bus_we && bus_addr == 5'h08;
    assign wr_chi   = bus_we && bus_addr == 5'h0C;
    assign wr_sip   = bus_we && bus_addr == 5'h10;

    assign irq_req   = state == REQ;
    assign irq_cause = state == IDLE ? 32'd0 : cause_q;
    assign mip_bits  = {meip, mtip, msip_q};

    always_comb begin
        rd_mux = bus_addr == 5'h00 ? mtime[31:0]
               : bus_addr == 5'h04 ? mtime[63:32]
               : bus_addr == 5'h08 ? mtimecmp[31:0]
               : bus_addr == 5'h0C ? mtimecmp[63:32]
               : bus_addr == 5'h10 ? {31'd0, msip_q}
               : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_sync <= '0;
            meip     <= 1'b0;
        end else begin
            ext_sync <= {ext_sync[1:0], ext_irq_in};
            // a fresh edge outranks the clear from an external-cause ack
            meip     <= ext_rise ? 1'b1
                      : (state == REQ && irq_ack && cause_q == CAUSE_EXT) ? 1'b0
                      : meip;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt     <= '0;
            mtime    <= '0;
            mtimecmp <= '1;
            msip_q   <= 1'b0;
        end else begin
            pcnt <= tick ? 32'd0 : pcnt + 32'd1;
            if (wr_tlo)
                mtime[31:0] <= bus_wdata;
            else if (wr_thi)
                mtime[63:32] <= bus_wdata;
            else if (tick)
                mtime <= mtime + 64'd1;
            if (wr_clo)
                mtimecmp[31:0] <= bus_wdata;
            if (wr_chi)
                mtimecmp[63:32] <= bus_wdata;
            if (wr_sip)
                msip_q <= bus_wdata[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_rdata  <= '0;
            bus_rvalid <= 1'b0;
        end else begin
            bus_rvalid <= bus_re;
            if (bus_re)
                bus_rdata <= rd_mux;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cause_q <= '0;
        end else begin
            case (state)
                IDLE: if (meip || msip_q || mtip) begin
                    state   <= REQ;
                    cause_q <= meip ? CAUSE_EXT : msip_q ? CAUSE_SW : CAUSE_TMR;
                end
                REQ:  if (irq_ack) state <= BUSY;
                BUSY: if (irq_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed and randomized checks of irq_ctrl against a
// cycle-level behavioural model of the register map and request handshake.
module tb_irq_ctrl;
    localparam int P = 1;
    localparam logic [31:0] C_EXT = 32'h8000_000B;
    localparam logic [31:0] C_SW  = 32'h8000_0003;
    localparam logic [31:0] C_TMR = 32'h8000_0007;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic        bus_we = 1'b0;
    logic        bus_re = 1'b0;
    logic        ext_irq_in = 1'b0;
    logic        irq_ack = 1'b0;
    logic        irq_done = 1'b0;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic        irq_req;
    logic [31:0] irq_cause;
    logic [2:0]  mip_bits;

    irq_ctrl #(.PRESCALE(P)) dut (
        .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .ext_irq_in(ext_irq_in), .irq_ack(irq_ack), .irq_done(irq_done),
        .irq_req(irq_req), .irq_cause(irq_cause), .mip_bits(mip_bits)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model: 0 idle, 1 requesting, 2 being serviced
    int          m_phase;
    logic [31:0] m_cause;
    logic [63:0] m_time, m_cmp;
    logic        m_msip, m_meip, m_rvalid;
    logic [31:0] m_rdata;
    logic [2:0]  ext_hist;
    int          m_pre;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_read(input logic [4:0] a);
        case (a)
            5'h00: return m_time[31:0];
            5'h04: return m_time[63:32];
            5'h08: return m_cmp[31:0];
            5'h0C: return m_cmp[63:32];
            5'h10: return {31'd0, m_msip};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cause = 0; m_time = 0; m_cmp = '1;
        m_msip = 0; m_meip = 0; m_rvalid = 0; m_rdata = 0; ext_hist = 0; m_pre = 0;
    endtask

    task automatic model_step();
        logic pend_t = m_time >= m_cmp;
        logic rise = ext_hist[1] && !ext_hist[2];
        int nphase = m_phase;
        logic [31:0] ncause = m_cause;
        logic time_wr = bus_we && (bus_addr == 5'h00 || bus_addr == 5'h04);
        if (bus_re) m_rdata = reg_read(bus_addr);
        m_rvalid = bus_re;
        if (m_phase == 0 && (m_meip || m_msip || pend_t)) begin
            nphase = 1;
            ncause = m_meip ? C_EXT : (m_msip ? C_SW : C_TMR);
        end else if (m_phase == 1 && irq_ack) nphase = 2;
        else if (m_phase == 2 && irq_done) nphase = 0;
        if (rise) m_meip = 1;
        else if (m_phase == 1 && irq_ack && m_cause == C_EXT) m_meip = 0;
        ext_hist = {ext_hist[1:0], ext_irq_in};
        if (!time_wr && m_pre == P - 1) m_time = m_time + 1;
        if (bus_we) begin
            if (bus_addr == 5'h00) m_time[31:0] = bus_wdata;
            if (bus_addr == 5'h04) m_time[63:32] = bus_wdata;
            if (bus_addr == 5'h08) m_cmp[31:0] = bus_wdata;
            if (bus_addr == 5'h0C) m_cmp[63:32] = bus_wdata;
            if (bus_addr == 5'h10) m_msip = bus_wdata[0];
        end
        m_pre = (m_pre + 1) % P;
        m_phase = nphase;
        m_cause = ncause;
    endtask

    task automatic compare_all();
        chk("irq_req", irq_req, m_phase == 1);
        chk("irq_cause", irq_cause, m_phase == 0 ? 32'd0 : m_cause);
        chk("mip_bits", mip_bits, {m_meip, m_time >= m_cmp, m_msip});
        chk("rvalid", bus_rvalid, m_rvalid);
        chk("rdata", bus_rdata, m_rdata);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1;
        model_reset();
        tick();
        tick();
        reset = 0;
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        bus_we = 1; bus_addr = a; bus_wdata = d;
        tick();
        bus_we = 0;
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
        bus_re = 1; bus_addr = a;
        tick();
        bus_re = 0;
        d = bus_rdata;
    endtask

    task automatic pulse(input logic ack, input logic done);
        irq_ack = ack; irq_done = done;
        tick();
        irq_ack = 0; irq_done = 0;
    endtask

    logic [31:0] rd;
    logic [4:0]  addrs [8];

    initial begin
        model_reset();
        do_reset();
        chk("rst_req", irq_req, 0);
        chk("rst_cause", irq_cause, 0);
        chk("rst_mip", mip_bits, 0);
        chk("rst_rvalid", bus_rvalid, 0);

        // external and software arrive in the same cycle: external wins
        ext_irq_in = 1;
        tick(); tick();
        bus_we = 1; bus_addr = 5'h10; bus_wdata = 1;
        tick();
        bus_we = 0; ext_irq_in = 0;
        chk("both_pend", mip_bits, 3'b101);
        chk("both_idle", irq_req, 0);
        tick();
        chk("ext_req", irq_req, 1);
        chk("ext_cause", irq_cause, C_EXT);
        pulse(1, 0);
        chk("ext_busy_req", irq_req, 0);
        chk("ext_busy_cause", irq_cause, C_EXT);
        chk("meip_clr", mip_bits[2], 0);
        pulse(0, 1);
        chk("idle_gap", irq_cause, 0);
        tick();
        chk("sw_req", irq_req, 1);
        chk("sw_cause", irq_cause, C_SW);

        // external edge during a software request leaves the cause alone
        ext_irq_in = 1;
        tick(); tick(); tick();
        ext_irq_in = 0;
        chk("meip_set", mip_bits[2], 1);
        chk("sw_hold", irq_cause, C_SW);
        pulse(1, 0);
        chk("meip_kept", mip_bits[2], 1);
        chk("sw_busy", irq_cause, C_SW);
        pulse(0, 1);
        tick();
        chk("ext_after", irq_cause, C_EXT);

        // ack and done together only advance to BUSY
        pulse(1, 1);
        chk("ackdone_req", irq_req, 0);
        chk("ackdone_cause", irq_cause, C_EXT);
        tick();
        chk("still_busy", irq_cause, C_EXT);
        pulse(0, 1);
        chk("back_idle", irq_cause, 0);

        // simultaneous read and write return the old value
        bus_re = 1; bus_we = 1; bus_addr = 5'h10; bus_wdata = 0;
        tick();
        bus_re = 0; bus_we = 0;
        chk("rw_old", bus_rdata, 1);
        chk("rw_msip", mip_bits[0], 0);

        // unmapped address
        bus_rd(5'h08, rd);
        chk("cmp_lo", rd, 32'hFFFF_FFFF);
        bus_rd(5'h14, rd);
        chk("unmap_rd", rd, 0);
        chk("unmap_rvalid", bus_rvalid, 1);
        bus_wr(5'h14, 32'hFFFF_FFFF);
        bus_rd(5'h04, rd);
        chk("unmap_thi", rd, 0);
        bus_rd(5'h0C, rd);
        chk("unmap_chi", rd, 32'hFFFF_FFFF);
        bus_rd(5'h10, rd);
        chk("unmap_sip", rd, 0);

        // carry from low to high word, then full 64-bit wrap
        bus_wr(5'h04, 0);
        bus_wr(5'h00, 32'hFFFF_FFFF);
        tick();
        bus_rd(5'h00, rd);
        chk("carry_lo", rd, 0);
        bus_rd(5'h04, rd);
        chk("carry_hi", rd, 1);
        bus_wr(5'h04, 32'hFFFF_FFFF);
        bus_wr(5'h00, 32'hFFFF_FFFF);
        tick();
        bus_rd(5'h00, rd);
        chk("wrap_lo", rd, 0);
        bus_rd(5'h04, rd);
        chk("wrap_hi", rd, 0);

        // timer compare at 0x10
        do_reset();
        bus_wr(5'h08, 32'h10);
        bus_wr(5'h0C, 0);
        for (int i = 0; i < 64 && !mip_bits[1]; i++) tick();
        chk("tmr_mtip", mip_bits[1], 1);
        chk("tmr_noreq_yet", irq_req, 0);
        bus_rd(5'h00, rd);
        chk("tmr_time", rd, 32'h10);
        chk("tmr_req", irq_req, 1);
        chk("tmr_cause", irq_cause, C_TMR);

        // asynchronous reset in the middle of a request
        do_reset();
        bus_wr(5'h10, 1);
        tick();
        chk("pre_rst_req", irq_req, 1);
        #2 reset = 1;
        #1;
        chk("async_req", irq_req, 0);
        chk("async_cause", irq_cause, 0);
        model_reset();
        tick();
        reset = 0;
        bus_rd(5'h08, rd);
        chk("rst_cmp_lo", rd, 32'hFFFF_FFFF);
        bus_rd(5'h0C, rd);
        chk("rst_cmp_hi", rd, 32'hFFFF_FFFF);

        // randomized traffic against the model
        addrs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h1C, 5'h02};
        for (int n = 0; n < 3000; n++) begin
            bus_re = $urandom_range(0, 3) == 0;
            bus_we = $urandom_range(0, 5) == 0;
            bus_addr = $urandom_range(0, 9) == 0 ? 5'($urandom) : addrs[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0: bus_wdata = 0;
                1: bus_wdata = $urandom_range(0, 64);
                default: bus_wdata = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ext_irq_in = ~ext_irq_in;
            irq_ack = $urandom_range(0, 4) == 0;
            irq_done = $urandom_range(0, 4) == 0;
            tick();
        end
        bus_re = 0; bus_we = 0; irq_ack = 0; irq_done = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter PRESCALE, default 1: mtime increments once every PRESCALE clk cycles (PRESCALE >= 1).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 bus_addr  input  5  word register select: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 MSIP.
REQ-005 bus_wdata  input  32  write data.
REQ-006 bus_we  input  1  write strobe, one write per cycle.
REQ-007 bus_re  input  1  read strobe.
REQ-008 bus_rdata  output  32  registered read data.
REQ-009 bus_rvalid  output  1  high for exactly one cycle, one cycle after bus_re.
REQ-010 ext_irq_in  input  1  asynchronous external interrupt line.
REQ-011 irq_ack  input  1  one-cycle pulse from the CSR file: interrupt taken.
REQ-012 irq_done  input  1  one-cycle pulse from the CSR file: mret executed.
REQ-013 irq_req  output  1  interrupt request to the CSR file.
REQ-014 irq_cause  output  32  mcause value for the request.
REQ-015 mip_bits  output  3  {meip, mtip, msip} for the CSR mip register.

Function
REQ-016 ext_irq_in SHALL pass through a 2-flop synchronizer; a synchronized rising edge SHALL set the sticky meip latch.
REQ-017 meip SHALL clear on the irq_ack cycle when the accepted cause is external; a new edge in the same cycle SHALL win (meip stays 1).
REQ-018 A prescaler SHALL count 0..PRESCALE-1; mtime (64-bit) SHALL increment on the terminal count and wrap 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-019 A bus write to MTIME_LO/HI SHALL replace that half and suppress the increment in that cycle; the prescaler SHALL not reset.
REQ-020 mtip SHALL equal the unsigned 64-bit compare mtime >= mtimecmp, evaluated combinationally from registered values.
REQ-021 msip SHALL equal MSIP register bit 0; bits 31:1 SHALL read as 0.
REQ-022 Reads of unmapped addresses SHALL return 0; writes to them SHALL be ignored.
REQ-023 A read and a write to the same address in one cycle SHALL return the pre-write value.
REQ-024 The FSM SHALL have states IDLE, REQ, BUSY.
REQ-025 IDLE -> REQ when any of meip/msip/mtip is set; priority meip > msip > mtip; the winner's cause SHALL be latched on entry.
REQ-026 Cause encodings: external 0x8000_000B, software 0x8000_0003, timer 0x8000_0007.
REQ-027 irq_req SHALL be 1 only in REQ; irq_cause SHALL hold the latched value in REQ and BUSY and be 0 in IDLE.
REQ-028 The latched cause SHALL not change while in REQ, even if a higher-priority source arrives.
REQ-029 REQ -> BUSY on irq_ack; an irq_ack outside REQ SHALL be ignored.
REQ-030 BUSY -> IDLE on irq_done; an irq_done outside BUSY SHALL be ignored.
REQ-031 A source still pending on return to IDLE SHALL raise a new request on the following cycle (one IDLE cycle minimum).
REQ-032 irq_ack and irq_done arriving together in REQ SHALL take REQ -> BUSY only.

Reset
REQ-033 On reset: FSM IDLE, mtime 0, prescaler 0, mtimecmp 0xFFFF_FFFF_FFFF_FFFF, MSIP 0, meip 0, synchronizer 0, irq_req 0, irq_cause 0, bus_rdata 0, bus_rvalid 0.
REQ-034 Reset asserted mid-request SHALL drop irq_req within the same cycle (asynchronous) with no ack required.

Verification
REQ-035 PRESCALE=1, mtimecmp=0x0000_0000_0000_0010 -> mtip rises when mtime=0x10, irq_req=1 with irq_cause=0x8000_0007 one cycle later.
REQ-036 MTIME_LO=0xFFFF_FFFF, MTIME_HI=0 -> after one increment, MTIME_HI reads 1 and MTIME_LO reads 0.
REQ-037 Set MSIP=1 and pulse ext_irq_in together in IDLE -> request cause 0x8000_000B; after ack and done, new request cause 0x8000_0003.
REQ-038 In REQ with cause 0x8000_0003, pulse ext_irq_in -> cause unchanged until ack; meip stays set; after done, request 0x8000_000B.
REQ-039 Read 0x14 -> bus_rvalid=1 next cycle with bus_rdata=0; write 0x14 -> no register changes.
REQ-040 Assert reset while irq_req=1 -> irq_req=0 immediately, mtimecmp reads 0xFFFF_FFFF in both halves after reset release.
